ex_stage: RTL

Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs and computes the ALU result, branch/jump resolution and redirect target. It forwards operands from MEM and WB, and registers the results into the EX/MEM pipeline register that feeds the data-memory stage. Redirect and flush are generated here and drive the flush inputs of the IF/ID and ID/EX registers.

---
 rtl/ex_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ALU, branch/jump resolution, and the EX/MEM register.
// Define EX_FWD_EN to compile in operand forwarding from MEM and WB.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        memread_EX,
  input  logic        memwrite_EX,
  input  logic        regwrite_EX,
  input  logic        j_EX,
  input  logic        br_EX,
  input  logic [31:0] PC_EX,
  input  logic [31:0] rs1_data_EX,
  input  logic [31:0] rs2_data_EX,
  input  logic [31:0] imm_EX,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [4:0]  rd_EX,
  input  logic        jalr_EX,
  input  logic        sub_EX,
  input  logic        sra_EX,
  input  logic        shdir_EX,
  input  logic        Asrc_EX,
  input  logic        Bsrc_EX,
  input  logic [2:0]  funct3_EX,
  input  logic [2:0]  ALUOP_EX,
  input  logic        regwrite_WB,
  input  logic [4:0]  rd_WB,
  input  logic [31:0] wb_data_WB,
  output logic        flush,
  output logic [31:0] redirect_PC,
  output logic        memread_MEM,
  output logic        memwrite_MEM,
  output logic        regwrite_MEM,
  output logic [31:0] alu_result_MEM,
  output logic [31:0] store_data_MEM,
  output logic [4:0]  rd_MEM,
  output logic [2:0]  funct3_MEM
);

  logic [31:0] fwd_rs1, fwd_rs2;

`ifdef EX_FWD_EN
  // MEM wins over WB; a load in MEM has no data yet, and x0 is never forwarded.
  function automatic logic [31:0] forward(input logic [4:0] idx, input logic [31:0] rf_data);
    if (regwrite_MEM && !memread_MEM && rd_MEM != 5'd0 && rd_MEM == idx)
      return alu_result_MEM;
    else if (regwrite_WB && rd_WB != 5'd0 && rd_WB == idx)
      return wb_data_WB;
    else
      return rf_data;
  endfunction

  assign fwd_rs1 = forward(rs1_EX, rs1_data_EX);
  assign fwd_rs2 = forward(rs2_EX, rs2_data_EX);
`else
  assign fwd_rs1 = rs1_data_EX;
  assign fwd_rs2 = rs2_data_EX;

  logic unused_fwd;
  assign unused_fwd = ^{regwrite_WB, rd_WB, wb_data_WB, rs1_EX, rs2_EX};
`endif

  logic [31:0] op_a, op_b, alu_out, target;
  logic [4:0]  shamt;
  logic        cond, taken;

  assign op_a  = Asrc_EX ? PC_EX : fwd_rs1;
  assign op_b  = Bsrc_EX ? imm_EX : fwd_rs2;
  assign shamt = op_b[4:0];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_out = op_b;
    case (ALUOP_EX)
      3'b000: alu_out = sub_EX ? op_a - op_b : op_a + op_b;
      3'b001: begin
        if (!shdir_EX)   alu_out = op_a << shamt;
        else if (sra_EX) alu_out = 32'($signed(op_a) >>> shamt);
        else             alu_out = op_a >> shamt;
      end
      3'b010: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011: alu_out = {31'd0, op_a < op_b};
      3'b100: alu_out = op_a ^ op_b;
      3'b101: alu_out = op_a | op_b;
      3'b110: alu_out = op_a & op_b;
      default: alu_out = op_b;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (funct3_EX)
      3'b000: cond = fwd_rs1 == fwd_rs2;
      3'b001: cond = fwd_rs1 != fwd_rs2;
      3'b100: cond = $signed(fwd_rs1) < $signed(fwd_rs2);
      3'b101: cond = $signed(fwd_rs1) >= $signed(fwd_rs2);
      3'b110: cond = fwd_rs1 < fwd_rs2;
      3'b111: cond = fwd_rs1 >= fwd_rs2;
      default: cond = 1'b0;
    endcase
  end

  // A stalled redirect is held back so ID/EX does not wipe the instruction still waiting in EX.
  assign taken       = ~stall & (j_EX | (br_EX & cond));
  assign target      = jalr_EX ? ((fwd_rs1 + imm_EX) & ~32'd1) : (PC_EX + imm_EX);
  assign flush       = taken;
  assign redirect_PC = target;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memread_MEM    <= 1'b0;
      memwrite_MEM   <= 1'b0;
      regwrite_MEM   <= 1'b0;
      alu_result_MEM <= 32'd0;
      store_data_MEM <= 32'd0;
      rd_MEM         <= 5'd0;
      funct3_MEM     <= 3'd0;
    end else if (!stall) begin
      memread_MEM    <= memread_EX;
      memwrite_MEM   <= memwrite_EX;
      regwrite_MEM   <= regwrite_EX;
      alu_result_MEM <= j_EX ? PC_EX + 32'd4 : alu_out;
      store_data_MEM <= fwd_rs2;
      rd_MEM         <= rd_EX;
      funct3_MEM     <= funct3_EX;
    end
  end

endmodule
